// File: rtl/clk_reset_sequencer.sv
// -----------------------------------------------------------------------------
// clk_reset_sequencer
//
// Brings up the board PLL and releases the system reset once the PLL has been
// locked long enough. The block runs on the free-running board reference clock
// and does the following:
//   - pulses the PLL reset for a fixed number of cycles,
//   - waits for LOCKED, with a timeout and a bounded number of retries,
//   - requires lock to stay stable for a programmable time before it releases
//     the 6809 core/peripheral reset tree.
//
// Losing lock while running re-runs the whole sequence. Running out of
// retries parks the block in a sticky fault state, which only nRESET or
// SW_REQ can leave.
//
// Ports
//   CLK          in   board reference clock (also the PLL reference)
//   nRESET       in   synchronous active-low reset
//   LOCKED       in   PLL lock flag, asynchronous to CLK
//   SW_REQ       in   single-cycle request to restart the sequence
//   PLL_RESET    out  active-high PLL reset, high only while pulsing the PLL
//   SYS_nRESET   out  active-low system reset, released only in RUN
//   READY        out  high only in RUN
//   FAULT        out  sticky, lock never achieved within MAX_RETRIES attempts
//   RETRY_COUNT  out  failed attempts in the current sequence (saturating)
//
// All outputs come straight from flops. They are loaded from the next-state
// decode, so each one changes on the same edge as the state it reflects.
// -----------------------------------------------------------------------------
module clk_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 3,
    parameter int CW             = 16
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       LOCKED,
    input  logic       SW_REQ,
    output logic       PLL_RESET,
    output logic       SYS_nRESET,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAILED    = 3'd4
    } state_t;

    // Terminal counts for the shared counter. Each phase starts the counter
    // at zero.
    localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRIES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    logic          lk_meta_r;
    logic          lk_sync_r;
    logic          lk_s;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [3:0]    retry_r;
    logic [3:0]    retry_nxt_s;
    logic          fault_r;
    logic          fault_nxt_s;

    logic          pll_reset_r;
    logic          sys_nreset_r;
    logic          ready_r;

    // Two-flop synchronizer that brings LOCKED into the CLK domain.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            lk_meta_r <= 1'b0;
            lk_sync_r <= 1'b0;
        end else begin
            lk_meta_r <= LOCKED;
            lk_sync_r <= lk_meta_r;
        end
    end

    assign lk_s = lk_sync_r;

    // Next-state, counter, retry and fault logic. SW_REQ overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_nxt_s = retry_r;
        fault_nxt_s = fault_r;
        if (SW_REQ) begin
            state_nxt_s = ST_PLL_RST;
            cnt_nxt_s   = {CW{1'b0}};
            retry_nxt_s = 4'd0;
            fault_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_PLL_RST: begin
                    if (cnt_r == PLL_LAST) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first, so lock on the timeout cycle wins.
                    if (lk_s) begin
                        state_nxt_s = ST_STABLE;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else if (cnt_r == LOCK_LAST) begin
                        cnt_nxt_s = {CW{1'b0}};
                        if (retry_r < RETRY_MAX) begin
                            retry_nxt_s = retry_r + 4'd1;
                        end else begin
                            retry_nxt_s = retry_r;
                        end
                        if (retry_r >= RETRY_LAST) begin
                            state_nxt_s = ST_FAILED;
                            fault_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_PLL_RST;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_STABLE: begin
                    // A lock glitch here is not a failed attempt. The PLL is
                    // not reset; the block only waits for lock again.
                    if (!lk_s) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        state_nxt_s = ST_PLL_RST;
                        cnt_nxt_s   = {CW{1'b0}};
                        retry_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FAILED: begin
                    state_nxt_s = ST_FAILED;
                end
                default: begin
                    // An unreachable encoding recovers by restarting the
                    // sequence.
                    state_nxt_s = ST_PLL_RST;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, counter, retry and fault registers.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_r <= ST_PLL_RST;
            cnt_r   <= {CW{1'b0}};
            retry_r <= 4'd0;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            retry_r <= retry_nxt_s;
            fault_r <= fault_nxt_s;
        end
    end

    // Output flops, loaded from the next-state decode so they track the state.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            pll_reset_r  <= 1'b1;
            sys_nreset_r <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            pll_reset_r  <= (state_nxt_s == ST_PLL_RST);
            sys_nreset_r <= (state_nxt_s == ST_RUN);
            ready_r      <= (state_nxt_s == ST_RUN);
        end
    end

    assign PLL_RESET   = pll_reset_r;
    assign SYS_nRESET  = sys_nreset_r;
    assign READY       = ready_r;
    assign FAULT       = fault_r;
    assign RETRY_COUNT = retry_r;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_reset_sequencer
//
// Self-checking bench for clk_reset_sequencer.
//
// The reference model counts down the cycles left in each phase. Every cycle
// the bench compares all outputs against the model. Targeted checks then pin
// the edge numbers of the key events in the directed scenarios.
//
// Edge numbering: edge k is the k-th rising edge after nRESET is released,
// counting from 0.
// -----------------------------------------------------------------------------
module tb_clk_reset_sequencer;

    localparam int PRC  = 16;
    localparam int LTO  = 4096;
    localparam int STC  = 256;
    localparam int MAXR = 3;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       LOCKED = 1'b0;
    logic       SW_REQ = 1'b0;
    logic       PLL_RESET;
    logic       SYS_nRESET;
    logic       READY;
    logic       FAULT;
    logic [3:0] RETRY_COUNT;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_phase = P_RST;
    int m_left  = PRC;
    int m_retry = 0;
    bit m_fault = 1'b0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    always #5 CLK = ~CLK;

    clk_reset_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .STABLE_CYCLES (STC),
        .MAX_RETRIES   (MAXR),
        .CW            (16)
    ) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .LOCKED     (LOCKED),
        .SW_REQ     (SW_REQ),
        .PLL_RESET  (PLL_RESET),
        .SYS_nRESET (SYS_nRESET),
        .READY      (READY),
        .FAULT      (FAULT),
        .RETRY_COUNT(RETRY_COUNT)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference model by one rising edge.
    task automatic model_step(input bit nr, input bit lk, input bit sw);
        bit seen;
        if (!nr) begin
            m_phase = P_RST;
            m_left  = PRC;
            m_retry = 0;
            m_fault = 1'b0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = lk;
            if (sw) begin
                m_phase = P_RST;
                m_left  = PRC;
                m_retry = 0;
                m_fault = 1'b0;
            end else if (m_phase == P_RST) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_WAIT;
                    m_left  = LTO;
                end
            end else if (m_phase == P_WAIT) begin
                if (seen) begin
                    m_phase = P_STAB;
                    m_left  = STC;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_retry + 1 >= MAXR) begin
                            m_phase = P_FAIL;
                            m_fault = 1'b1;
                        end else begin
                            m_phase = P_RST;
                            m_left  = PRC;
                        end
                        if (m_retry < MAXR) m_retry++;
                    end
                end
            end else if (m_phase == P_STAB) begin
                if (!seen) begin
                    m_phase = P_WAIT;
                    m_left  = LTO;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = P_RUN;
                end
            end else if (m_phase == P_RUN) begin
                if (!seen) begin
                    m_phase = P_RST;
                    m_left  = PRC;
                    m_retry = 0;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        return {(m_phase == P_RST), (m_phase == P_RUN), (m_phase == P_RUN), m_fault, 4'(m_retry)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {PLL_RESET, SYS_nRESET, READY, FAULT, RETRY_COUNT};
    endfunction

    // Drive one cycle of inputs, take the edge, then compare against the model.
    task automatic tick(input bit nr, input bit lk, input bit sw);
        nRESET = nr;
        LOCKED = lk;
        SW_REQ = sw;
        @(posedge CLK);
        model_step(nr, lk, sw);
        #1;
        check_val("outputs", 32'(dut_vec()), 32'(exp_vec()));
        if (errors > 30) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    endtask

    task automatic do_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pulse;
        int rise;
        int fall;
        int falls;
        bit prev;
        bit pll_seen;
        bit lkv;
        int run_left;

        // 1: clean boot, then reset asserted together with SW_REQ.
        do_reset();
        check_val("reset_vec", 32'(dut_vec()), 32'h80);
        pulse = 0;
        rise  = -1;
        for (int k = 0; k < 350; k++) begin
            if (PLL_RESET) pulse++;
            tick(1'b1, (k >= 40), 1'b0);
            if (SYS_nRESET && rise < 0) rise = k;
        end
        check_val("boot_pll_len", pulse, PRC);
        check_val("boot_rise", rise, 298);
        check_val("boot_retry", 32'(RETRY_COUNT), 0);
        check_val("boot_ready", 32'(READY), 1);
        tick(1'b0, 1'b1, 1'b1);
        check_val("rst_over_sw", 32'(dut_vec()), 32'h80);

        // 2: lock never arrives, so FAULT is raised; SW_REQ then clears it.
        do_reset();
        falls = 0;
        prev  = PLL_RESET;
        for (int k = 0; k < 12346; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (prev && !PLL_RESET) falls++;
            prev = PLL_RESET;
            if (k == 4110) check_val("retry_pll_low", 32'(PLL_RESET), 0);
            if (k == 4111) check_val("retry_pll_high", 32'(PLL_RESET), 1);
            if (k == 12334) check_val("fault_early", 32'(FAULT), 0);
            if (k == 12335) check_val("fault_set", 32'(FAULT), 1);
        end
        check_val("timeout_pulses", falls, 3);
        check_val("timeout_retry", 32'(RETRY_COUNT), 3);
        check_val("timeout_sysn", 32'(SYS_nRESET), 0);
        tick(1'b1, 1'b0, 1'b1);
        check_val("sw_clr_fault", 32'(FAULT), 0);
        check_val("sw_pll", 32'(PLL_RESET), 1);
        check_val("sw_retry", 32'(RETRY_COUNT), 0);

        // 3: a 5-cycle lock glitch during STABLE, then 4: lock loss in RUN.
        do_reset();
        pll_seen = 1'b0;
        rise = -1;
        for (int k = 0; k < 450; k++) begin
            tick(1'b1, (k >= 40) && !(k >= 143 && k <= 147), 1'b0);
            if (k >= 16 && PLL_RESET) pll_seen = 1'b1;
            if (SYS_nRESET && rise < 0) rise = k;
        end
        check_val("glitch_no_pll", 32'(pll_seen), 0);
        check_val("glitch_rise", rise, 406);
        check_val("glitch_retry", 32'(RETRY_COUNT), 0);
        fall  = -1;
        pulse = 0;
        for (int k = 450; k < 760; k++) begin
            tick(1'b1, (k >= 480), 1'b0);
            if (!SYS_nRESET && fall < 0) fall = k;
            if (PLL_RESET) pulse++;
        end
        check_val("loss_fall", fall, 452);
        check_val("loss_pll_len", pulse, PRC);
        check_val("loss_retry", 32'(RETRY_COUNT), 0);
        check_val("loss_rerun", 32'(READY), 1);

        // 5: SW_REQ in the same cycle as the synchronized lock in WAIT_LOCK.
        do_reset();
        for (int k = 0; k < 30; k++) tick(1'b1, (k >= 28), 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        check_val("sw_over_lock", 32'(PLL_RESET), 1);
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b1, 1'b0);

        // 6: the synchronized lock arrives exactly on the timeout cycle.
        do_reset();
        rise = -1;
        for (int k = 0; k < 4400; k++) begin
            tick(1'b1, (k >= 4109), 1'b0);
            if (k == 4111) begin
                check_val("edge_lock_retry", 32'(RETRY_COUNT), 0);
                check_val("edge_lock_pll", 32'(PLL_RESET), 0);
            end
            if (SYS_nRESET && rise < 0) rise = k;
        end
        check_val("edge_lock_rise", rise, 4367);

        // Random run: lock runs of mixed length, sparse SW_REQ and nRESET.
        do_reset();
        lkv = 1'b0;
        run_left = 0;
        for (int k = 0; k < 20000; k++) begin
            if (run_left == 0) begin
                lkv = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       run_left = $urandom_range(1, 8);
                    1:       run_left = $urandom_range(200, 400);
                    default: run_left = $urandom_range(3000, 6000);
                endcase
            end
            run_left--;
            tick(($urandom_range(0, 3999) != 0), lkv, ($urandom_range(0, 1999) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
